// File: rtl/weight_pkg.sv
// Shared weight-buffer layout: layer codes, region bases, block counts and the
// block-to-address mapping used by both the weight distributer and the weight reader.
package weight_pkg;

    localparam int WB_ADDR_W    = 12;
    localparam int WB_DATA_W    = 72;
    localparam int BLK_WORDS    = 8;
    localparam int FIFO_DEPTH   = 2;

    localparam logic [WB_ADDR_W-1:0] CONV1_BASE = 12'd0;
    localparam logic [WB_ADDR_W-1:0] CONV2_BASE = 12'd32;
    localparam logic [WB_ADDR_W-1:0] FC_BASE    = 12'd160;

    localparam int CONV1_BLOCKS = 1;
    localparam int CONV2_BLOCKS = 16;
    localparam int FC_BLOCKS    = 320;

    typedef enum logic [1:0] {
        LAYER_CONV1 = 2'd0,
        LAYER_CONV2 = 2'd1,
        LAYER_FC    = 2'd2,
        LAYER_NONE  = 2'd3
    } layer_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } rd_state_e;

    function automatic logic blk_legal(input logic [1:0] layer, input logic [8:0] blk);
        logic ok;
        ok = 1'b0;
        case (layer)
            LAYER_CONV1: ok = ({23'd0, blk} < CONV1_BLOCKS);
            LAYER_CONV2: ok = ({23'd0, blk} < CONV2_BLOCKS);
            LAYER_FC:    ok = ({23'd0, blk} < FC_BLOCKS);
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

    // FC blocks interleave: bit 0 picks a 32-word half, bits 2:1 an 8-word slot,
    // bits 8:3 a 64-word group, matching the distributer's write order.
    function automatic logic [WB_ADDR_W-1:0] blk_base(input logic [1:0] layer,
                                                     input logic [8:0] blk);
        logic [WB_ADDR_W-1:0] a;
        a = CONV1_BASE;
        case (layer)
            LAYER_CONV2: a = CONV2_BASE + {5'd0, blk[3:0], 3'd0};
            LAYER_FC:    a = FC_BASE + {6'd0, blk[0], 5'd0}
                                     + {7'd0, blk[2:1], 3'd0}
                                     + {blk[8:3], 6'd0};
            default:     a = CONV1_BASE;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/weight_reader_fifo.sv
// Two-entry output FIFO holding {word index, weight word}; the head is forced to
// zero while empty so the block outputs read 0 after reset.
module weight_reader_fifo #(
    parameter int DATA_W = 72
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [2:0]        push_idx,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [1:0]        count,
    output logic              head_vld,
    output logic [2:0]        head_idx,
    output logic [DATA_W-1:0] head_data
);

    logic [DATA_W-1:0] mem_data [2];
    logic [2:0]        mem_idx  [2];
    logic              wr_ptr;
    logic              rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Storage is not reset; a push into a full FIFO only happens together with a pop
    // of the same slot, whose old contents are consumed this cycle.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= push_data;
            mem_idx[wr_ptr]  <= push_idx;
        end
    end

    assign head_vld  = (count != 2'd0);
    assign head_data = head_vld ? mem_data[rd_ptr] : '0;
    assign head_idx  = head_vld ? mem_idx[rd_ptr]  : 3'd0;

endmodule

// File: rtl/weight_reader.sv
// Weight reader: fetches one 8-word block from the weight buffer BRAM and streams it
// over a valid/ready port. Optional WEIGHT_READER_CHECKSUM_EN adds a per-block byte sum.
module weight_reader
    import weight_pkg::*;
#(
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DATA_W = WB_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_layer,
    input  logic [8:0]        req_block,
    output logic              wbuf_enb,
    output logic [ADDR_W-1:0] wbuf_addrb,
    input  logic [DATA_W-1:0] wbuf_doutb,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        out_idx,
    output logic              out_last,
    output logic              done,
    output logic              req_err,
    output logic              busy,
    output logic [15:0]       checksum
);

    rd_state_e         state_q, state_d;
    logic [2:0]        k_p0;
    logic [ADDR_W-1:0] base_p0;
    logic              err_q;
    logic              rd_vld_p1;
    logic [2:0]        rd_idx_p1;
    logic [1:0]        fifo_count;
    logic              accept;
    logic              legal;
    logic              issue;
    logic              pop;
    logic              fifo_left_zero;

    assign accept = req_valid && (state_q == ST_IDLE);
    assign legal  = blk_legal(req_layer, req_block);
    assign pop    = out_valid && out_ready;

    // Words committed after this edge (buffered + returning - leaving) must fit the FIFO.
    assign issue = (state_q == ST_READ) &&
                   (({1'b0, fifo_count} + {2'b00, rd_vld_p1} - {2'b00, pop}) < 3'(FIFO_DEPTH));

    assign fifo_left_zero = (fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = legal ? ST_READ : ST_FIN;
            ST_READ:  if (issue && (k_p0 == 3'(BLK_WORDS - 1))) state_d = ST_DRAIN;
            ST_DRAIN: if (!rd_vld_p1 && fifo_left_zero) state_d = ST_FIN;
            ST_FIN:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Stage p0: request latch and read issue
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            k_p0    <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                k_p0  <= 3'd0;
                err_q <= !legal;
            end else if (issue) begin
                k_p0 <= k_p0 + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) base_p0 <= blk_base(req_layer, req_block);
    end

    assign wbuf_enb   = issue;
    assign wbuf_addrb = issue ? (base_p0 + {{(ADDR_W-3){1'b0}}, k_p0}) : '0;

    // Stage p1: BRAM return captured into the FIFO
    always_ff @(posedge clk) begin
        if (reset) rd_vld_p1 <= 1'b0;
        else       rd_vld_p1 <= issue;
    end

    always_ff @(posedge clk) begin
        rd_idx_p1 <= k_p0;
    end

    weight_reader_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rd_vld_p1),
        .push_idx  (rd_idx_p1),
        .push_data (wbuf_doutb),
        .pop       (pop),
        .count     (fifo_count),
        .head_vld  (out_valid),
        .head_idx  (out_idx),
        .head_data (out_data)
    );

    assign out_last  = out_valid && (out_idx == 3'(BLK_WORDS - 1));
    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_FIN);
    assign req_err   = done && err_q;

`ifdef WEIGHT_READER_CHECKSUM_EN
    function automatic logic [15:0] byte_sum(input logic [DATA_W-1:0] w);
        logic signed [7:0]  b;
        logic signed [15:0] acc;
        acc = '0;
        for (int j = 0; j < DATA_W / 8; j++) begin
            b   = w[j*8 +: 8];
            acc = acc + 16'(b);
        end
        return acc;
    endfunction

    logic [15:0] cks_q;

    // Accumulates delivered words only, so rejected requests leave it at zero.
    always_ff @(posedge clk) begin
        if (reset)       cks_q <= 16'd0;
        else if (accept) cks_q <= 16'd0;
        else if (pop)    cks_q <= cks_q + byte_sum(out_data);
    end

    assign checksum = cks_q;
`else
    assign checksum = 16'd0;
`endif

endmodule

// File: tb/tb_weight_reader.sv
// Scoreboard bench for weight_reader: BRAM model, expected address/beat queues filled
// by the stimulus tasks and drained by an independent negedge monitor.
module tb_weight_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_layer;
    logic [8:0]  req_block;
    logic        wbuf_enb;
    logic [11:0] wbuf_addrb;
    logic [71:0] wbuf_doutb;
    logic        out_valid;
    logic        out_ready;
    logic [71:0] out_data;
    logic [2:0]  out_idx;
    logic        out_last;
    logic        done;
    logic        req_err;
    logic        busy;
    logic [15:0] checksum;

    always #5 clk = ~clk;

    weight_reader dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_layer  (req_layer),
        .req_block  (req_block),
        .wbuf_enb   (wbuf_enb),
        .wbuf_addrb (wbuf_addrb),
        .wbuf_doutb (wbuf_doutb),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .done       (done),
        .req_err    (req_err),
        .busy       (busy),
        .checksum   (checksum)
    );

    logic [71:0] mem [0:2719];

    always @(posedge clk) begin
        if (wbuf_enb) wbuf_doutb <= mem[wbuf_addrb];
    end

    typedef struct {
        logic [71:0] d;
        logic [2:0]  idx;
    } beat_t;

    int    addr_q[$];
    beat_t beat_q[$];
    int    vectors    = 0;
    int    miscompares = 0;
    int    issued     = 0;
    int    popped     = 0;

    function automatic logic [71:0] pat(input int a);
        logic [71:0] w;
        for (int j = 0; j < 9; j++) w[j*8 +: 8] = 8'(a * 7 + j * 37 + (a >> 8));
        return w;
    endfunction

    function automatic logic [15:0] cks_of(input int base);
        logic [15:0] s;
        logic [7:0]  b;
        logic [71:0] w;
        s = 16'd0;
        for (int k = 0; k < 8; k++) begin
            w = mem[base + k];
            for (int j = 0; j < 9; j++) begin
                b = w[j*8 +: 8];
                s = s + {{8{b[7]}}, b};
            end
        end
        return s;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every read address and every delivered beat is checked against the queues.
    initial begin
        beat_t b;
        int    a;
        forever begin
            @(negedge clk);
            if (wbuf_enb) begin
                issued++;
                if (addr_q.size() == 0) chk("spurious_read", wbuf_addrb, 128'hx);
                else begin
                    a = addr_q.pop_front();
                    chk("rd_addr", wbuf_addrb, 128'(a));
                end
            end
            if (out_valid && out_ready) begin
                popped++;
                if (beat_q.size() == 0) chk("spurious_beat", out_data, 128'hx);
                else begin
                    b = beat_q.pop_front();
                    chk("beat_data", out_data, b.d);
                    chk("beat_idx", out_idx, b.idx);
                    chk("beat_last", out_last, (b.idx == 3'd7));
                end
            end
            chk("occupancy_le2", ((issued - popped) <= 2), 1);
        end
    end

    task automatic do_req(input logic [1:0] layer, input logic [8:0] blk, input int base,
                          input bit legal, input bit toggle, input string tag);
        logic [3:0] rdy_pat;
        int         cyc;
        bit         seen;
        logic [15:0] exp_cks;
        rdy_pat = 4'b1001;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_layer = layer;
        req_block = blk;
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_req_ready"}, req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_layer = 2'd0;
        req_block = 9'd0;
        out_ready = toggle ? rdy_pat[0] : 1'b1;
        if (legal) begin
            for (int k = 0; k < 8; k++) begin
                addr_q.push_back(base + k);
                beat_q.push_back('{d: mem[base + k], idx: 3'(k)});
            end
        end
        seen = 1'b0;
        for (cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (cyc == 0) chk({tag, "_enb_c0"}, wbuf_enb, legal);
            if (!toggle && legal && cyc == 1) chk({tag, "_valid_c1"}, out_valid, 0);
            if (!toggle && legal && cyc == 2) chk({tag, "_valid_c2"}, out_valid, 1);
            if (!toggle && legal && cyc == 9) chk({tag, "_last_c9"}, out_valid && out_last, 1);
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
            if (toggle) out_ready = rdy_pat[(cyc + 1) % 4];
        end
        if (!seen) chk({tag, "_done_timeout"}, 0, 1);
        else begin
            if (!toggle) chk({tag, "_done_cycle"}, cyc, legal ? 10 : 0);
            chk({tag, "_req_err"}, req_err, !legal);
            chk({tag, "_words_left"}, beat_q.size() + addr_q.size(), 0);
`ifdef WEIGHT_READER_CHECKSUM_EN
            exp_cks = legal ? cks_of(base) : 16'd0;
`else
            exp_cks = 16'd0;
`endif
            chk({tag, "_checksum"}, checksum, exp_cks);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_after_done"}, {done, req_err, busy, req_ready}, 4'b0001);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ctl"}, {req_ready, busy, done, req_err, out_valid, out_last, wbuf_enb},
            7'b1000000);
        chk({tag, "_data"}, {out_data, out_idx, wbuf_addrb, checksum}, 0);
    endtask

    task automatic reset_mid_block();
        bit reached;
        int bad;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_layer = 2'd2;
        req_block = 9'd1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            addr_q.push_back(192 + k);
            beat_q.push_back('{d: mem[192 + k], idx: 3'(k)});
        end
        reached = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (popped >= 3) begin
                reached = 1'b1;
                break;
            end
        end
        if (!reached) chk("rst_wait_3_beats", 0, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        addr_q.delete();
        beat_q.delete();
        issued = 0;
        popped = 0;
        @(negedge clk);
        chk_idle_outputs("rst_mid");
        bad = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done || out_valid || wbuf_enb || busy) bad++;
        end
        chk("rst_quiet_after", bad, 0);
        do_req(2'd0, 9'd0, 0, 1'b1, 1'b0, "post_rst_conv1");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 2720; a++) mem[a] = pat(a);
        reset     = 1'b1;
        req_valid = 1'b0;
        req_layer = 2'd0;
        req_block = 9'd0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        do_req(2'd0, 9'd0,   0,    1'b1, 1'b0, "conv1_b0");
        do_req(2'd2, 9'd1,   192,  1'b1, 1'b0, "fc_b1");
        do_req(2'd2, 9'd2,   168,  1'b1, 1'b0, "fc_b2");
        do_req(2'd2, 9'd319, 2712, 1'b1, 1'b0, "fc_b319");
        do_req(2'd1, 9'd5,   72,   1'b1, 1'b1, "conv2_b5_bp");
        do_req(2'd1, 9'd16,  0,    1'b0, 1'b0, "conv2_b16");
        do_req(2'd3, 9'd0,   0,    1'b0, 1'b0, "layer3");
        do_req(2'd0, 9'd1,   0,    1'b0, 1'b0, "conv1_b1");
        do_req(2'd2, 9'd320, 0,    1'b0, 1'b0, "fc_b320");
        do_req(2'd1, 9'd15,  152,  1'b1, 1'b1, "conv2_b15_bp");
        reset_mid_block();
`ifdef WEIGHT_READER_CHECKSUM_EN
        for (int a = 0; a < 8; a++) mem[a] = {72{1'b1}};
        do_req(2'd0, 9'd0, 0, 1'b1, 1'b0, "cks_ff");
        chk("cks_ff_value", checksum, 16'hFFB8);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
